// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/burst encodings and the burst-length helper
// used by the bus arbiter.
package ahb_pkg;

  localparam int MASTER_IDX_W = 4;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  // Undefined-length INCR counts as a single beat so it can be re-arbitrated every beat.
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    case (burst)
      HB_WRAP4, HB_INCR4:   burst_len = 5'd4;
      HB_WRAP8, HB_INCR8:   burst_len = 5'd8;
      HB_WRAP16, HB_INCR16: burst_len = 5'd16;
      default:              burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational rotating-priority picker: the requester closest after the
// current index wins, with the current index itself searched last.
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]  i_req,
  input  logic [MASTER_IDX_W-1:0] i_cur,
  output logic [NUM_MASTERS-1:0]  o_grant,
  output logic                    o_valid
);

  logic [4:0] w_cur;
  logic [4:0] w_jIdx;
  logic [4:0] w_pri;
  logic [4:0] w_bestPri;

  assign w_cur = {1'b0, i_cur};

  // Each candidate gets a distance 1..NUM_MASTERS from the current index; smallest wins.
  always_comb begin
    o_grant   = '0;
    o_valid   = 1'b0;
    w_bestPri = 5'h1f;
    w_jIdx    = '0;
    w_pri     = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      w_jIdx = 5'(j);
      w_pri  = (w_jIdx > w_cur) ? (w_jIdx - w_cur) : (w_jIdx + 5'(NUM_MASTERS) - w_cur);
      if (i_req[j] && (w_pri < w_bestPri)) begin
        w_bestPri  = w_pri;
        o_grant    = '0;
        o_grant[j] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: registered one-hot grant, address-phase owner and
// lock flag, holding the bus across fixed-length bursts and locked sequences.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                    HCLK_i,
  input  logic                    HRESET_i,
  input  logic [NUM_MASTERS-1:0]  HBUSREQ_i,
  input  logic [NUM_MASTERS-1:0]  HLOCK_i,
  input  logic [1:0]              HTRANS_i,
  input  logic [2:0]              HBURST_i,
  input  logic                    HREADY_i,
  output logic [NUM_MASTERS-1:0]  HGRANT_o,
  output logic [MASTER_IDX_W-1:0] HMASTER_o,
  output logic                    HMASTLOCK_o
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0]  r_grant;
  logic [MASTER_IDX_W-1:0] r_master;
  logic                    r_mastLock;
  logic [3:0]              r_rem;

  logic [3:0]              w_remNext;
  logic [MASTER_IDX_W-1:0] w_grantIdx;
  logic                    w_lockG;
  logic                    w_arbAllowed;
  logic [NUM_MASTERS-1:0]  w_pickGrant;
  logic                    w_pickValid;

  always_comb begin
    w_grantIdx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) w_grantIdx = MASTER_IDX_W'(i);
    end
  end

  assign w_lockG = |(HLOCK_i & r_grant);

  always_comb begin
    w_remNext = r_rem;
    case (HTRANS_i)
      HT_IDLE:   w_remNext = '0;
      HT_BUSY:   w_remNext = r_rem;
      HT_NONSEQ: w_remNext = 4'(burst_len(HBURST_i) - 5'd1);
      HT_SEQ:    w_remNext = (r_rem != 4'd0) ? (r_rem - 4'd1) : 4'd0;
      default:   w_remNext = r_rem;
    endcase
  end

  // Switching at rem_next<=1 lets the next owner's address phase follow the last beat.
  assign w_arbAllowed = HREADY_i && (w_remNext <= 4'd1) && !w_lockG;

  ahb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .i_req   (HBUSREQ_i),
    .i_cur   (w_grantIdx),
    .o_grant (w_pickGrant),
    .o_valid (w_pickValid)
  );

  always_ff @(posedge HCLK_i) begin
    if (HRESET_i) begin
      r_grant    <= DEF_GRANT;
      r_master   <= MASTER_IDX_W'(DEFAULT_MASTER);
      r_mastLock <= 1'b0;
      r_rem      <= '0;
    end else if (HREADY_i) begin
      r_rem      <= w_remNext;
      r_master   <= w_grantIdx;
      r_mastLock <= w_lockG;
      if (w_arbAllowed) r_grant <= w_pickValid ? w_pickGrant : DEF_GRANT;
    end
  end

  assign HGRANT_o    = r_grant;
  assign HMASTER_o   = r_master;
  assign HMASTLOCK_o = r_mastLock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_ahb_bus_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [1:0]   trans;
  logic [2:0]   burst;
  logic         ready;
  logic [N-1:0] HGRANT_o;
  logic [3:0]   HMASTER_o;
  logic         HMASTLOCK_o;

  int testCount = 0;
  int failCount = 0;

  int mGrant, mMaster, mLock, mRem;
  bit modelValid = 1'b0;
  int lenTab [0:7] = '{1, 1, 4, 4, 8, 8, 16, 16};

  always #5 clk = ~clk;

  ahb_bus_arbiter #(
    .NUM_MASTERS(N),
    .DEFAULT_MASTER(DEF)
  ) dut (
    .HCLK_i      (clk),
    .HRESET_i    (rst),
    .HBUSREQ_i   (req),
    .HLOCK_i     (lock),
    .HTRANS_i    (trans),
    .HBURST_i    (burst),
    .HREADY_i    (ready),
    .HGRANT_o    (HGRANT_o),
    .HMASTER_o   (HMASTER_o),
    .HMASTLOCK_o (HMASTLOCK_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l, input logic [1:0] t,
                               input logic [2:0] b, input logic rdy, input logic rs);
    req = r; lock = l; trans = t; burst = b; ready = rdy; rst = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic int rrPick(input logic [N-1:0] r, input int cur);
    for (int k = 1; k <= N; k++) begin
      if (r[(cur + k) % N]) return (cur + k) % N;
    end
    return DEF;
  endfunction

  // Reference model: plain integer bookkeeping of grant, owner and remaining beats.
  always @(posedge clk) begin
    int remNext;
    int locked;
    if (rst) begin
      mGrant = DEF; mMaster = DEF; mLock = 0; mRem = 0;
      modelValid = 1'b1;
    end else if (ready) begin
      case (trans)
        2'd0:    remNext = 0;
        2'd1:    remNext = mRem;
        2'd2:    remNext = lenTab[burst] - 1;
        default: remNext = (mRem > 0) ? mRem - 1 : 0;
      endcase
      locked  = int'(lock[mGrant]);
      mMaster = mGrant;
      mLock   = locked;
      if (remNext <= 1 && locked == 0) mGrant = rrPick(req, mGrant);
      mRem = remNext;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("modelGrant", 32'(HGRANT_o), 32'(1 << mGrant));
      checkOutput("modelMaster", 32'(HMASTER_o), 32'(mMaster));
      checkOutput("modelLock", 32'(HMASTLOCK_o), 32'(mLock));
      checkOutput("onehot", 32'($onehot(HGRANT_o)), 32'd1);
    end
  end

  logic [N-1:0] rotExp;

  initial begin
    // Reset and idle hold
    applyStimulus(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);
    checkOutput("rstGrant", 32'(HGRANT_o), 32'b0001);
    checkOutput("rstMaster", 32'(HMASTER_o), 32'd0);
    checkOutput("rstLock", 32'(HMASTLOCK_o), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    checkOutput("idleHoldGrant", 32'(HGRANT_o), 32'b0001);

    // First grant and ownership
    applyStimulus(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    checkOutput("firstGrant", 32'(HGRANT_o), 32'b0010);
    applyStimulus(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    checkOutput("firstOwner", 32'(HMASTER_o), 32'd1);

    // INCR4 by master 1 with master 2 waiting
    applyStimulus(4'b0110, 4'b0000, 2'd2, 3'd3, 1'b1, 1'b0);
    checkOutput("incr4Beat1", 32'(HGRANT_o), 32'b0010);
    applyStimulus(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 1'b0);
    checkOutput("incr4Beat2", 32'(HGRANT_o), 32'b0010);
    applyStimulus(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 1'b0);
    checkOutput("incr4Beat3", 32'(HGRANT_o), 32'b0100);
    checkOutput("incr4Beat3Own", 32'(HMASTER_o), 32'd1);
    applyStimulus(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 1'b0);
    checkOutput("incr4Beat4Own", 32'(HMASTER_o), 32'd2);

    // Same INCR4 with a three-cycle stall after beat 2
    applyStimulus(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    checkOutput("stallSetup", 32'(HMASTER_o), 32'd1);
    applyStimulus(4'b0110, 4'b0000, 2'd2, 3'd3, 1'b1, 1'b0);
    applyStimulus(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b0, 1'b0);
      checkOutput("stallGrant", 32'(HGRANT_o), 32'b0010);
      checkOutput("stallOwner", 32'(HMASTER_o), 32'd1);
    end
    applyStimulus(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 1'b0);
    checkOutput("stallBeat3", 32'(HGRANT_o), 32'b0100);
    applyStimulus(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 1'b0);
    checkOutput("stallBeat4Own", 32'(HMASTER_o), 32'd2);

    // Locked singles by master 1 with master 3 waiting
    applyStimulus(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1010, 4'b0010, 2'd2, 3'd0, 1'b1, 1'b0);
      checkOutput("lockGrant", 32'(HGRANT_o), 32'b0010);
      checkOutput("lockFlag", 32'(HMASTLOCK_o), 32'd1);
    end
    applyStimulus(4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    checkOutput("unlockGrant", 32'(HGRANT_o), 32'b1000);

    // All masters request with single transfers
    rotExp = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 1'b0);
      checkOutput("rotate", 32'(HGRANT_o), 32'(rotExp));
      rotExp = {rotExp[N-2:0], rotExp[N-1]};
    end

    // Reset in the middle of a locked INCR8
    applyStimulus(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    applyStimulus(4'b1111, 4'b0100, 2'd2, 3'd5, 1'b1, 1'b0);
    applyStimulus(4'b1111, 4'b0100, 2'd3, 3'd5, 1'b1, 1'b0);
    applyStimulus(4'b1111, 4'b0100, 2'd3, 3'd5, 1'b1, 1'b0);
    checkOutput("incr8Grant", 32'(HGRANT_o), 32'b0100);
    checkOutput("incr8Lock", 32'(HMASTLOCK_o), 32'd1);
    applyStimulus(4'b1111, 4'b0100, 2'd3, 3'd5, 1'b1, 1'b1);
    checkOutput("midRstGrant", 32'(HGRANT_o), 32'b0001);
    checkOutput("midRstMaster", 32'(HMASTER_o), 32'd0);
    checkOutput("midRstLock", 32'(HMASTLOCK_o), 32'd0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(4'($urandom),
                    ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000,
                    2'($urandom), 3'($urandom),
                    ($urandom_range(3) != 0),
                    ($urandom_range(99) == 0));
    end

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin AHB bus arbiter for the APB2AHB bridge's AHB side. Grants one of NUM_MASTERS requesters, tracks ownership of the address phase, and holds the bus for the full length of fixed-length bursts and locked sequences. It drives the HGRANT/HMASTER/HMASTLOCK signals consumed by the master-side address/data muxes and by every AHB slave.

## Interface
- NUM_MASTERS, 4: number of requesting masters, range 2..16.
- DEFAULT_MASTER, 0: index granted when no master requests.
- HCLK_i  in  1  bus clock; all logic on the rising edge.
- HRESET_i  in  1  synchronous, active-high reset.
- HBUSREQ_i  in  NUM_MASTERS  bus request, one bit per master.
- HLOCK_i  in  NUM_MASTERS  locked-transfer request, one bit per master.
- HTRANS_i  in  2  transfer type of the current address-phase owner.
- HBURST_i  in  3  burst type of the current address-phase owner.
- HREADY_i  in  1  bus-wide transfer-complete.
- HGRANT_o  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER_o  out  4  index of the current address-phase owner, registered.
- HMASTLOCK_o  out  1  current owner's transfer is locked, registered.

## Operation
- Reset values:
  - HGRANT_o = 1<<DEFAULT_MASTER.
  - HMASTER_o = DEFAULT_MASTER.
  - HMASTLOCK_o = 0.
  - Remaining-beat counter rem = 0.
- Beat counter: updates only on an edge with HREADY_i=1.
  - NONSEQ loads rem with len-1, where len = 1 for SINGLE/INCR, 4 for WRAP4/INCR4, 8 for WRAP8/INCR8, 16 for WRAP16/INCR16.
  - SEQ decrements rem, saturating at 0.
  - IDLE clears rem to 0.
  - BUSY holds rem.
  - rem_next is the value rem takes at this edge.
- Re-arbitration is allowed at an edge only if all hold:
  - HREADY_i=1;
  - rem_next<=1;
  - HLOCK_i[g]=0, where g is the index held in HGRANT_o.
- Otherwise HGRANT_o holds.
- Round-robin pick, done by a combinational picker:
  - Search indices g+1, g+2, …, wrapping, ending at g itself.
  - The first requester wins.
  - If there are no requests, grant DEFAULT_MASTER.
- Ownership: on an edge with HREADY_i=1, HMASTER_o takes g and HMASTLOCK_o takes HLOCK_i[g]. Both use the pre-edge HGRANT_o, so ownership trails the grant by one accepted transfer.
- INCR (undefined length) is treated as single beats: re-arbitration is possible on every accepted beat.
- Reset mid-burst or mid-lock: everything returns to reset values on the next edge, with no drain of the burst or locked sequence.

## Timing
- Latency from request to grant: 1 edge when arbitration is allowed.
- Latency from grant to ownership: next edge with HREADY_i=1.
- HREADY_i=0 freezes all state: rem, HGRANT_o, HMASTER_o and HMASTLOCK_o.
- Fixed burst of N beats: the grant changes at the edge accepting beat N-1, so the new owner's address phase follows beat N with no idle cycle.
- A request dropped while granted is released only at the next allowed arbitration point.
- When requests arrive and arbitration is allowed at the same edge, the request is seen in that edge's pick. Requests are not latched.
- HGRANT_o is always exactly one-hot. The verification bench asserts this every cycle.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - HBURST encodings: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
  - A burst-length function.
- One sub-module, ahb_rr_picker: combinational rotate-priority pick. Parameter NUM_MASTERS. Inputs: requests and the current index. Outputs: one-hot grant and a valid flag.

## Test plan
- Reset with DEFAULT_MASTER=0 and no requests -> HGRANT_o=0001, HMASTER_o=0, HMASTLOCK_o=0, holding indefinitely.
- HBUSREQ_i=0110, HREADY_i=1, HTRANS_i=IDLE -> HGRANT_o=0010 after edge 1, HMASTER_o=1 after edge 2.
- Master 1 owns the bus and issues INCR4 (NONSEQ, SEQ, SEQ, SEQ) while master 2 requests:
  - HGRANT_o stays 0010 through beat 2 and becomes 0100 at the edge accepting beat 3.
  - HMASTER_o=2 at the edge accepting beat 4.
- The same INCR4 with HREADY_i=0 for 3 cycles after beat 2 -> no output change during the stall; the grant switch slips by exactly 3 cycles.
- Master 1 holds HLOCK_i=1 across 3 single transfers while master 3 requests:
  - HGRANT_o=0010 and HMASTLOCK_o=1 throughout.
  - After HLOCK_i[1] drops, the next accepting edge gives HGRANT_o=1000.
- All masters request with continuous single transfers -> grants rotate 0001, 0010, 0100, 1000, 0001. HRESET_i asserted mid-INCR8 -> reset values on the next edge.
